// File: rtl/me_scan_ctrl.sv
// ---------------------------------------------------------------------------
// me_scan_ctrl -- full-search motion-estimation scan sequencer.
//
// Drives a BLK-wide systolic PE array over NV vertical displacement passes.
// A single scan lasts TOTAL = NV*BLK*BLK + BLK cycles: NV passes of BLK*BLK
// cycles followed by a BLK-cycle drain that only flushes peready for the
// last pass. All decoded outputs are combinational from the registered
// state and count, and read 0 outside RUN.
//
// Optional build macro: ME_SCAN_STALL_EN adds the stall input, which freezes
// the scan (count and all decoded outputs) while high in RUN.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   level, sampled in IDLE only
//   stall      in   scan freeze (only with ME_SCAN_STALL_EN)
//   busy       out  high while in RUN
//   done       out  one-cycle pulse after the last scan cycle
//   s1s2mux    out  per-PE S1/S2 operand select
//   newdist    out  per-PE distortion latch strobe
//   peready    out  per-PE result-valid strobe
//   compstart  out  comparator enable
//   vectorx    out  candidate x displacement, two's complement
//   vectory    out  candidate y displacement, two's complement
//   addr_r     out  reference-block address
//   addr_s1    out  search-window address, left half
//   addr_s2    out  search-window address, right half
// ---------------------------------------------------------------------------
module me_scan_ctrl #(
    parameter int BLK = 16,
    parameter int NV  = 16
) (
    input  logic                                        clock,
    input  logic                                        reset_n,
    input  logic                                        start,
`ifdef ME_SCAN_STALL_EN
    input  logic                                        stall,
`endif
    output logic                                        busy,
    output logic                                        done,
    output logic [BLK-1:0]                              s1s2mux,
    output logic [BLK-1:0]                              newdist,
    output logic [BLK-1:0]                              peready,
    output logic                                        compstart,
    output logic [$clog2(BLK)-1:0]                      vectorx,
    output logic [$clog2(NV)-1:0]                       vectory,
    output logic [$clog2(BLK*BLK)-1:0]                  addr_r,
    output logic [$clog2((NV+BLK-1)*(2*BLK-1))-1:0]     addr_s1,
    output logic [$clog2((NV+BLK-1)*(2*BLK-1))-1:0]     addr_s2
);

    localparam int W     = 2*BLK - 1;
    localparam int BB    = BLK*BLK;
    localparam int TOTAL = NV*BB + BLK;
    localparam int CW    = $clog2(TOTAL);
    localparam int XW    = $clog2(BLK);
    localparam int YW    = $clog2(NV);
    localparam int RW    = $clog2(BB);
    localparam int VW    = CW - RW;       // pass index incl. drain pass (== NV)
    localparam int SW    = $clog2((NV+BLK-1)*W);
    localparam int IW    = ((SW > CW) ? SW : CW) + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_s;
    logic            advance_s;

    // Decomposition of the current count (power-of-two sizes -> bit slices).
    logic [RW-1:0]   p_s;
    logic [VW-1:0]   v_s;
    logic [XW-1:0]   r_s;
    logic [XW-1:0]   c_s;
    // Same decomposition of count-BLK, used by the right-half address.
    logic [CW-1:0]   t_s;
    logic [VW-1:0]   vt_s;
    logic [XW-1:0]   rt_s;
    logic [XW-1:0]   ct_s;

`ifdef ME_SCAN_STALL_EN
    assign advance_s = ~stall;
`else
    assign advance_s = 1'b1;
`endif

    assign p_s  = count_r[RW-1:0];
    assign v_s  = count_r[CW-1:RW];
    assign r_s  = p_s[RW-1:XW];
    assign c_s  = p_s[XW-1:0];
    assign t_s  = count_r - CW'(BLK);
    assign vt_s = t_s[CW-1:RW];
    assign rt_s = t_s[RW-1:XW];
    assign ct_s = t_s[XW-1:0];

    assign busy = (state_r == ST_RUN);
    assign done = (state_r == ST_DONE);

    // State and scan counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            count_r <= '0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    count_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!advance_s) begin
                    count_s = count_r;
                end else if (count_r == CW'(TOTAL-1)) begin
                    state_s = ST_DONE;
                    count_s = '0;
                end else begin
                    count_s = count_r + CW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                count_s = '0;
            end
            default: begin
                state_s = ST_IDLE;
                count_s = '0;
            end
        endcase
    end

    // Output decode; everything reads 0 outside RUN.
    always_comb begin
        s1s2mux   = '0;
        newdist   = '0;
        peready   = '0;
        compstart = 1'b0;
        vectorx   = '0;
        vectory   = '0;
        addr_r    = '0;
        addr_s1   = '0;
        addr_s2   = '0;
        if (state_r == ST_RUN) begin
            compstart = (count_r >= CW'(BB));
            for (int i = 0; i < BLK; i++) begin
                newdist[i] = (p_s == RW'(i));
                peready[i] = (p_s == RW'(i)) && (count_r >= CW'(BB));
                s1s2mux[i] = (c_s >= XW'(i));
            end
            addr_r  = p_s;
            // Subtracting half the range re-centres the displacement around 0;
            // in the drain pass vectory wraps and is meaningless.
            vectorx = c_s - XW'(BLK/2);
            vectory = v_s[YW-1:0] - YW'(NV/2);
            if (v_s < VW'(NV)) begin
                addr_s1 = SW'(((IW'(v_s) + IW'(r_s)) * IW'(W)) + IW'(c_s));
            end else begin
                addr_s1 = '0;
            end
            // Right half lags the left by BLK cycles; no wrap before that.
            if ((count_r >= CW'(BLK)) && (v_s < VW'(NV))) begin
                addr_s2 = SW'(((IW'(vt_s) + IW'(rt_s)) * IW'(W)) + IW'(ct_s) + IW'(BLK));
            end else begin
                addr_s2 = '0;
            end
        end else begin
            compstart = 1'b0;
        end
    end

endmodule

// File: doc/me_scan_ctrl.md
Name: me_scan_ctrl

Overview:
Parametrised successor to the fixed 16x16 full-search motion-estimation sequencer. It drives a BLK-wide systolic PE array over NV vertical displacement passes. Outputs include reference/search memory addresses, the S1/S2 operand mux, distortion-latch strobes, PE-ready strobes and the current candidate motion vector. Unlike its predecessor it adds a start/busy/done handshake, an asynchronous reset, explicit drain and IDLE states, and generic block and search sizes.

Parameters:
BLK, 16, block edge in pixels = number of PEs = horizontal displacements; power of two, 2..64
NV, 16, number of vertical displacement passes; power of two, 2..64
W (localparam), 2*BLK-1, search-window row pitch
TOTAL (localparam), NV*BLK*BLK+BLK, scan length in cycles (4112 at defaults)
CW (localparam), clog2(TOTAL), counter width

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE only
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last scan cycle
s1s2mux  out  BLK  per-PE S1/S2 operand select
newdist  out  BLK  per-PE distortion latch strobe
peready  out  BLK  per-PE result-valid strobe
compstart  out  1  comparator enable
vectorx  out  clog2(BLK)  candidate x displacement, two's complement
vectory  out  clog2(NV)  candidate y displacement, two's complement
addr_r  out  clog2(BLK*BLK)  reference-block address
addr_s1  out  clog2((NV+BLK-1)*W)  search-window address, left half
addr_s2  out  same as addr_s1  search-window address, right half
stall  in  1  present only with ME_SCAN_STALL_EN

Behaviour:
- Reset (async, reset_n=0): state IDLE, count=0, busy=0, done=0. Every decoded output is 0. Release is synchronous to clock.
- States:
  - IDLE: start=1 moves to RUN with count=0 at the next edge.
  - RUN: count increments by 1 per cycle. When count==TOTAL-1, the next state is DONE and count clears.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- Restart: start held high continuously gives back-to-back scans separated by DONE plus one IDLE cycle.
- start in RUN is ignored.
- Reset mid-scan aborts immediately with no done pulse.
- Decode (combinational from registered count/state; all outputs 0 outside RUN). Terms:
  - p = count mod BLK*BLK; v = count / (BLK*BLK); r = p / BLK; c = p mod BLK.
  - newdist[i] = (p==i).
  - compstart = (count >= BLK*BLK).
  - peready[i] = newdist[i] & compstart.
  - s1s2mux[i] = (c >= i).
  - addr_r = p.
  - addr_s1 = (v+r)*W + c while v<NV. In the drain phase (v==NV) addr_s1 = 0.
  - addr_s2: with t = count-BLK decomposed the same way, addr_s2 = (vt+rt)*W + ct + BLK. addr_s2 = 0 while count<BLK (no wrap).
  - vectorx = c - BLK/2 and vectory = v - NV/2, each truncated to port width. In drain, vectory wraps modulo 2^width; do not use it there.
- Arithmetic: internal address math at least clog2((NV+BLK-1)*W)+1 bits, then truncated. No overflow is possible for legal parameters.
- Drain phase: the final BLK cycles (v==NV) only flush peready for the last pass. Memory addresses are don't-care and must read as 0.

Optional Feature:
ME_SCAN_STALL_EN: adds the stall input.
- With the macro: stall=1 in RUN freezes count and all decoded outputs. Freeze lasts as long as stall is high, including the final cycle; done is delayed accordingly. stall is ignored in IDLE and DONE.
- Without the macro: no stall port, and count advances every RUN cycle.

Test Plan:
- Defaults; reset_n low mid-run, then start pulse -> busy=1 one cycle later; count=0 gives addr_r=0, addr_s1=0, newdist[0]=1, vectorx=-8 (4'h8), vectory=-8.
- Defaults, count=0x123 -> addr_s1=96, addr_s2=81, addr_r=0x23, s1s2mux=16'h000F, compstart=1, peready=0.
- Defaults, count=256..271 -> peready[i] one-hot walking bit0..bit15. count=16..255 -> peready=0.
- Defaults full scan -> done pulses exactly 4112 cycles after busy rises, then busy=0. start held high -> next busy rises 2 cycles after done.
- BLK=4, NV=4 -> TOTAL=68; addr_s1 at count 63 = 6*7+3=45; drain counts 64..67 give addr_s1=0 and peready bits 0..3.
- ME_SCAN_STALL_EN, 5-cycle stall at count 100 -> outputs frozen; done delayed by exactly 5 cycles. Async reset during stall -> IDLE, no done.
